// File: rtl/song_sequencer.sv
// song_sequencer
//   Walks the selected song in a synchronous song ROM one {note, duration}
//   word at a time. Each word is handed to note_player with a one-cycle
//   load_new_note pulse. The sequencer then waits for done_with_note before
//   fetching the next word. The play level pauses the sequence, and a
//   zero-duration word or the last index of the song ends it.
//
// Ports
//   i_clk               system clock
//   i_reset             synchronous, active-high reset
//   i_play              level: 1 = run/resume, 0 = pause
//   i_song              song select, taken only on i_new_song
//   i_new_song          pulse: restart at word 0 of i_song
//   o_rom_addr          registered {song, note index} to the song ROM
//   i_rom_data          {note[11:6], duration[5:0]}, valid one cycle after o_rom_addr
//   o_note_to_load      registered note for note_player (0 = rest)
//   o_duration_to_load  registered duration in beats
//   o_load_new_note     one-cycle load strobe to note_player
//   i_done_with_note    note_player has finished the current note
//   o_play_enable       note_player run enable
//   o_song_done         one-cycle pulse on entering END
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for play after reset or a song change
// FETCH     | rom_addr holds the word being read; ROM is clocking it
// WAIT_ROM  | ROM word valid; latch it, or end on a zero duration
// LOAD      | load strobe to note_player
// WAIT_DONE | note playing; first cycle blanks a stale done flag
// END       | song finished; held until new_song or reset

module song_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int NOTE_BITS = 5
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_play,
  input  logic [SONG_BITS-1:0]           i_song,
  input  logic                           i_new_song,
  output logic [SONG_BITS+NOTE_BITS-1:0] o_rom_addr,
  input  logic [11:0]                    i_rom_data,
  output logic [5:0]                     o_note_to_load,
  output logic [5:0]                     o_duration_to_load,
  output logic                           o_load_new_note,
  input  logic                           i_done_with_note,
  output logic                           o_play_enable,
  output logic                           o_song_done
);

  localparam logic [NOTE_BITS-1:0] NOTE_LAST = {NOTE_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_LOAD,
    S_WAIT_DONE,
    S_END
  } state_t;

  state_t                           r_state;
  logic [SONG_BITS-1:0]             r_song;
  logic [NOTE_BITS-1:0]             r_note_idx;
  logic [SONG_BITS+NOTE_BITS-1:0]   r_rom_addr;
  logic [5:0]                       r_note;
  logic [5:0]                       r_duration;
  logic                             r_song_done;
  logic                             r_blank;

  logic [5:0]                       w_rom_note;
  logic [5:0]                       w_rom_duration;
  logic [NOTE_BITS-1:0]             w_next_idx;

  assign w_rom_note     = i_rom_data[11:6];
  assign w_rom_duration = i_rom_data[5:0];
  assign w_next_idx     = r_note_idx + NOTE_BITS'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_song      <= '0;
      r_note_idx  <= '0;
      r_rom_addr  <= '0;
      r_note      <= '0;
      r_duration  <= '0;
      r_song_done <= 1'b0;
      r_blank     <= 1'b0;
    end else begin
      r_song_done <= 1'b0;
      if (i_new_song) begin
        // Song change wins over everything, including a done in the same
        // cycle. The note/duration outputs keep their last values.
        r_song     <= i_song;
        r_note_idx <= '0;
        r_blank    <= 1'b0;
        r_state    <= S_IDLE;
      end else if (i_play) begin
        // With play low nothing below runs, so every state simply holds.
        case (r_state)
          S_IDLE: begin
            // The address is presented on entry to FETCH so that the
            // synchronous ROM returns the word during WAIT_ROM.
            r_rom_addr <= {r_song, r_note_idx};
            r_state    <= S_FETCH;
          end
          S_FETCH: begin
            r_state <= S_WAIT_ROM;
          end
          S_WAIT_ROM: begin
            if (w_rom_duration == 6'd0) begin
              r_song_done <= 1'b1;
              r_state     <= S_END;
            end else begin
              r_note     <= w_rom_note;
              r_duration <= w_rom_duration;
              r_state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_blank <= 1'b1;
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            // note_player may still show done from the previous note in
            // the cycle right after the load, so that cycle is skipped.
            if (r_blank) begin
              r_blank <= 1'b0;
            end else if (i_done_with_note) begin
              if (r_note_idx == NOTE_LAST) begin
                r_song_done <= 1'b1;
                r_state     <= S_END;
              end else begin
                r_note_idx <= w_next_idx;
                r_rom_addr <= {r_song, w_next_idx};
                r_state    <= S_FETCH;
              end
            end
          end
          S_END: begin
            r_state <= S_END;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // The strobe and enable are decoded from the registered state and gated
  // by play in the same cycle. This keeps a held LOAD silent during a
  // pause, and the strobe fires as soon as play returns.
  assign o_load_new_note    = (r_state == S_LOAD) && i_play && !i_new_song;
  assign o_play_enable      = i_play && (r_state != S_IDLE) && (r_state != S_END);

  assign o_rom_addr         = r_rom_addr;
  assign o_note_to_load     = r_note;
  assign o_duration_to_load = r_duration;
  assign o_song_done        = r_song_done;

endmodule
